// File: rtl/vga_cam_pkg.sv
// Shared types and sizes for the 160x120 RGB565 camera frame buffer.
package vga_cam_pkg;

    localparam int IMG_W  = 160;
    localparam int IMG_H  = 120;
    localparam int ADDR_W = $clog2(IMG_W * IMG_H);

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef enum logic {
        IDLE,
        FRAME
    } cap_state_t;

endpackage

// File: rtl/ov7670_frame_writer_if.sv
// Camera byte stream in, frame-buffer write port and status out.
interface ov7670_frame_writer_if #(
    parameter int AW = vga_cam_pkg::ADDR_W
) ();
    import vga_cam_pkg::*;

    logic          cam_pclk;
    logic          cam_vsync;
    logic          cam_href;
    logic [7:0]    cam_data;

    logic          we;
    logic [AW-1:0] wAddr;
    rgb565_t       wData;
    logic          frame_done;
    logic          line_err;

    modport master (
        output cam_pclk, cam_vsync, cam_href, cam_data,
        input  we, wAddr, wData, frame_done, line_err
    );

    modport slave (
        input  cam_pclk, cam_vsync, cam_href, cam_data,
        output we, wAddr, wData, frame_done, line_err
    );

endinterface

// File: rtl/ov7670_frame_writer_cam_sync.sv
// Two-flop synchroniser for the camera bus plus pclk/vsync edge detect.
module cam_sync (
    input  logic       clk,
    input  logic       reset,
    input  logic       pclk_i,
    input  logic       vsync_i,
    input  logic       href_i,
    input  logic [7:0] data_i,
    output logic       href_o,
    output logic [7:0] data_o,
    output logic       pclk_rise_o,
    output logic       vsync_rise_o,
    output logic       vsync_fall_o
);

    logic [10:0] s1_q;
    logic [10:0] s2_q;
    logic [1:0]  s3_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= {pclk_i, vsync_i, href_i, data_i};
            s2_q <= s1_q;
            s3_q <= s2_q[10:9];
        end
    end

    assign href_o       = s2_q[8];
    assign data_o       = s2_q[7:0];
    assign pclk_rise_o  = s2_q[10] & ~s3_q[1];
    assign vsync_rise_o = s2_q[9] & ~s3_q[0];
    assign vsync_fall_o = ~s2_q[9] & s3_q[0];

endmodule

// File: rtl/ov7670_frame_writer.sv
// Captures OV7670 RGB565 bytes, decimates 4x4 and writes the frame buffer.
module ov7670_frame_writer
    import vga_cam_pkg::*;
#(
    parameter int SRC_W    = 640,
    parameter int SRC_H    = 480,
    parameter int DEC_LOG2 = 2
) (
    input logic                 clk,
    input logic                 reset,
    ov7670_frame_writer_if.slave bus
);

    localparam int IW = SRC_W >> DEC_LOG2;
    localparam int IH = SRC_H >> DEC_LOG2;
    localparam int AW = $clog2(IW * IH);
    localparam logic [9:0] XMAX = 10'(SRC_W);
    localparam logic [8:0] YMAX = 9'(SRC_H);

    logic       href_s;
    logic [7:0] data_s;
    logic       pclk_rise;
    logic       vs_rise;
    logic       vs_fall;

    cam_sync u_sync (
        .clk          (clk),
        .reset        (reset),
        .pclk_i       (bus.cam_pclk),
        .vsync_i      (bus.cam_vsync),
        .href_i       (bus.cam_href),
        .data_i       (bus.cam_data),
        .href_o       (href_s),
        .data_o       (data_s),
        .pclk_rise_o  (pclk_rise),
        .vsync_rise_o (vs_rise),
        .vsync_fall_o (vs_fall)
    );

    cap_state_t    state_q;
    logic [9:0]    src_x_q;
    logic [8:0]    src_y_q;
    logic          phase_q;
    logic [7:0]    hi_q;
    logic          href_q;
    logic          we_q;
    logic [AW-1:0] waddr_q;
    rgb565_t       wdata_q;
    logic          fdone_q;
    logic          lerr_q;

    logic          dec_hit;
    logic [AW-1:0] addr_d;

    // Guarded by dec_hit, so the row/col casts never drop live bits.
    assign dec_hit = (src_x_q < XMAX) && (src_y_q < YMAX)
                  && (src_x_q[DEC_LOG2-1:0] == '0)
                  && (src_y_q[DEC_LOG2-1:0] == '0);
    assign addr_d  = AW'(IW) * AW'(src_y_q >> DEC_LOG2)
                   + AW'(src_x_q >> DEC_LOG2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            src_x_q <= '0;
            src_y_q <= '0;
            phase_q <= 1'b0;
            hi_q    <= '0;
            href_q  <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            fdone_q <= 1'b0;
            lerr_q  <= 1'b0;
        end else begin
            we_q    <= 1'b0;
            fdone_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (vs_fall) begin
                        state_q <= FRAME;
                        src_x_q <= '0;
                        src_y_q <= '0;
                        phase_q <= 1'b0;
                        href_q  <= 1'b0;
                    end
                end
                FRAME: begin
                    // vsync wins over any byte arriving on the same edge
                    if (vs_rise) begin
                        state_q <= IDLE;
                        if (src_y_q == YMAX) fdone_q <= 1'b1;
                        else                 lerr_q  <= 1'b1;
                    end else if (pclk_rise) begin
                        href_q <= href_s;
                        if (href_q && !href_s) begin
                            if (phase_q) lerr_q <= 1'b1;
                            src_x_q <= '0;
                            phase_q <= 1'b0;
                            if (src_y_q != YMAX) src_y_q <= src_y_q + 1'b1;
                        end else if (href_s) begin
                            if (!phase_q) begin
                                hi_q    <= data_s;
                                phase_q <= 1'b1;
                            end else begin
                                phase_q <= 1'b0;
                                if (src_x_q != '1) src_x_q <= src_x_q + 1'b1;
                                if (dec_hit) begin
                                    we_q    <= 1'b1;
                                    waddr_q <= addr_d;
                                    wdata_q <= rgb565_t'({hi_q, data_s});
                                end
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.we         = we_q;
    assign bus.wAddr      = waddr_q;
    assign bus.wData      = wdata_q;
    assign bus.frame_done = fdone_q;
    assign bus.line_err   = lerr_q;

endmodule
